// File: rtl/axi4_lite_master_ctrl.sv
// AXI4-Lite master: converts single-cycle local read/write requests into one bus
// transaction each; a simultaneous write+read is serialised write-first.
module axi4_lite_master_ctrl #(
    parameter int unsigned Addr_Width = 32,
    parameter int unsigned Data_Width = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [Addr_Width-1:0] Read_Address,
    input  logic [Addr_Width-1:0] Write_Address,
    input  logic [Data_Width-1:0] Write_Data,
    output logic                  busy,
    output logic [Data_Width-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  wr_done,
    output logic                  wr_err,
    output logic [Addr_Width-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [Data_Width-1:0] RDATA,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic                  RRESP,
    output logic [Addr_Width-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [Data_Width-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic                  BRESP
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_XFER = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;

    logic [2:0]            state_q,    state_d;
    logic                  pend_rd_q,  pend_rd_d;
    logic                  busy_q,     busy_d;
    logic [Addr_Width-1:0] araddr_q,   araddr_d;
    logic [Addr_Width-1:0] awaddr_q,   awaddr_d;
    logic [Data_Width-1:0] wdata_q,    wdata_d;
    logic                  arvalid_q,  arvalid_d;
    logic                  rready_q,   rready_d;
    logic                  awvalid_q,  awvalid_d;
    logic                  wvalid_q,   wvalid_d;
    logic                  bready_q,   bready_d;
    logic [Data_Width-1:0] rd_data_q,  rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_err_q,   rd_err_d;
    logic                  wr_done_q,  wr_done_d;
    logic                  wr_err_q,   wr_err_d;
    logic                  aw_left,    w_left;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        pend_rd_d  = pend_rd_q;
        araddr_d   = araddr_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_err_d   = rd_err_q;
        wr_done_d  = 1'b0;
        wr_err_d   = wr_err_q;
        aw_left    = awvalid_q & ~AWREADY;
        w_left     = wvalid_q & ~WREADY;

        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    awaddr_d  = Write_Address;
                    wdata_d   = Write_Data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_WR_XFER;
                    if (rd_en) begin
                        araddr_d  = Read_Address;
                        pend_rd_d = 1'b1;
                    end
                end else if (rd_en) begin
                    araddr_d  = Read_Address;
                    arvalid_d = 1'b1;
                    state_d   = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (RVALID) begin
                    rd_data_d  = RDATA;
                    rd_err_d   = RRESP;
                    rd_valid_d = 1'b1;
                    rready_d   = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_WR_XFER: begin
                // AW and W retire independently; response phase starts once both are gone
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (!aw_left && !w_left) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (BVALID) begin
                    wr_err_d  = BRESP;
                    wr_done_d = 1'b1;
                    bready_d  = 1'b0;
                    if (pend_rd_q) begin
                        pend_rd_d = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            pend_rd_q  <= 1'b0;
            busy_q     <= 1'b0;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_rd_q  <= pend_rd_d;
            busy_q     <= busy_d;
            araddr_q   <= araddr_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_done_q  <= wr_done_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign busy     = busy_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_done  = wr_done_q;
    assign wr_err   = wr_err_q;
    assign ARADDR   = araddr_q;
    assign ARVALID  = arvalid_q;
    assign RREADY   = rready_q;
    assign AWADDR   = awaddr_q;
    assign AWVALID  = awvalid_q;
    assign WDATA    = wdata_q;
    assign WVALID   = wvalid_q;
    assign BREADY   = bready_q;

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// Bench for axi4_lite_master_ctrl: transaction-queue reference model checked every
// cycle, plus directed scenarios with hand-derived expectations and a random phase.
module tb_axi4_lite_master_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          rd_en = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] Read_Address = '0, Write_Address = '0;
    logic [DW-1:0] Write_Data = '0;
    logic          busy, rd_valid, rd_err, wr_done, wr_err;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ARADDR, AWADDR;
    logic [DW-1:0] WDATA;
    logic          ARVALID, RREADY, AWVALID, WVALID, BREADY;
    logic          ARREADY = 1'b0, RVALID = 1'b0, RRESP = 1'b0;
    logic          AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, BRESP = 1'b0;
    logic [DW-1:0] RDATA = '0;

    int n_checks = 0;
    int n_errors = 0;

    axi4_lite_master_ctrl #(.Addr_Width(AW), .Data_Width(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .rd_en(rd_en), .wr_en(wr_en),
        .Read_Address(Read_Address), .Write_Address(Write_Address), .Write_Data(Write_Data),
        .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
        .wr_done(wr_done), .wr_err(wr_err),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted operations, head one is on the bus
    typedef struct packed {
        logic is_wr;
        logic a_done;
        logic w_done;
    } op_t;

    op_t           mq[$];
    logic          m_rd_valid = 1'b0, m_rd_err = 1'b0, m_wr_done = 1'b0, m_wr_err = 1'b0;
    logic [DW-1:0] m_rd_data = '0, m_wdata = '0;
    logic [AW-1:0] m_araddr = '0, m_awaddr = '0;

    task automatic model_step();
        op_t h;
        m_rd_valid = 1'b0;
        m_wr_done  = 1'b0;
        if (ARESET) begin
            mq.delete();
            m_rd_data = '0; m_rd_err = 1'b0; m_wr_err = 1'b0;
            m_araddr = '0; m_awaddr = '0; m_wdata = '0;
            return;
        end
        if (mq.size() != 0) begin
            h = mq[0];
            if (!h.is_wr) begin
                if (!h.a_done) begin
                    if (ARREADY) h.a_done = 1'b1;
                end else if (RVALID) begin
                    m_rd_data  = RDATA;
                    m_rd_err   = RRESP;
                    m_rd_valid = 1'b1;
                end
            end else if (h.a_done && h.w_done) begin
                if (BVALID) begin
                    m_wr_err  = BRESP;
                    m_wr_done = 1'b1;
                end
            end else begin
                if (AWREADY) h.a_done = 1'b1;
                if (WREADY)  h.w_done = 1'b1;
            end
            if (m_rd_valid || m_wr_done) void'(mq.pop_front());
            else mq[0] = h;
        end else begin
            if (wr_en) begin
                mq.push_back('{1'b1, 1'b0, 1'b0});
                m_awaddr = Write_Address;
                m_wdata  = Write_Data;
            end
            if (rd_en) begin
                mq.push_back('{1'b0, 1'b0, 1'b0});
                m_araddr = Read_Address;
            end
        end
    endtask

    function automatic logic [9:0] exp_ctrl();
        op_t  h;
        logic act;
        act = (mq.size() != 0);
        h   = act ? mq[0] : '0;
        return {act, m_rd_valid, m_rd_err, m_wr_done, m_wr_err,
                act & ~h.is_wr & ~h.a_done, act & ~h.is_wr & h.a_done,
                act & h.is_wr & ~h.a_done, act & h.is_wr & ~h.w_done,
                act & h.is_wr & h.a_done & h.w_done};
    endfunction

    function automatic logic [9:0] dut_ctrl();
        return {busy, rd_valid, rd_err, wr_done, wr_err, ARVALID, RREADY, AWVALID, WVALID, BREADY};
    endfunction

    // Per-cycle comparison of every DUT output against the model
    initial begin
        forever begin
            @(posedge ACLK);
            model_step();
            #1;
            chk("ctrl", 64'(dut_ctrl()), 64'(exp_ctrl()));
            chk("rd_data", 64'(rd_data), 64'(m_rd_data));
            chk("araddr", 64'(ARADDR), 64'(m_araddr));
            chk("awaddr", 64'(AWADDR), 64'(m_awaddr));
            chk("wdata", 64'(WDATA), 64'(m_wdata));
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic slave(input logic ar, input logic rv, input logic [DW-1:0] rd, input logic rr,
                         input logic aw, input logic w, input logic bv, input logic br);
        ARREADY = ar; RVALID = rv; RDATA = rd; RRESP = rr;
        AWREADY = aw; WREADY = w; BVALID = bv; BRESP = br;
    endtask

    // Issue one read; returns cycles from accept to rd_valid and the ARADDR seen with ARVALID
    task automatic do_read(input logic [AW-1:0] addr, output int lat, output logic [AW-1:0] seen);
        rd_en = 1'b1;
        Read_Address = addr;
        step();
        rd_en = 1'b0;
        lat  = 1;
        seen = '0;
        while (!rd_valid && lat < 12) begin
            if (ARVALID) seen = ARADDR;
            step();
            lat++;
        end
    endtask

    initial begin
        int            lat, wd_cnt, ar_cnt, aw_cnt, wr_c, rd_c, busy_drop;
        logic [AW-1:0] seen;

        step();
        step();
        ARESET = 1'b0;
        chk("rst_ctrl", 64'(dut_ctrl()), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        step();

        // Zero-wait read
        slave(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_read(32'h10, lat, seen);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_araddr", 64'(seen), 64'h10);
        chk("rd_data_a", 64'(rd_data), 64'hDEADBEEF);
        chk("rd_err_a", 64'(rd_err), 64'd0);
        step();

        // Write: AWREADY right away, WREADY three cycles later
        slave(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        wr_en = 1'b1; Write_Address = 32'h20; Write_Data = 32'h12345678;
        step();
        wr_en = 1'b0;
        chk("wr_c1_valids", 64'({AWVALID, WVALID}), 64'b11);
        chk("wr_c1_awaddr", 64'(AWADDR), 64'h20);
        chk("wr_c1_wdata", 64'(WDATA), 64'h12345678);
        step();
        chk("wr_c2_valids", 64'({AWVALID, WVALID}), 64'b01);
        step();
        step();
        chk("wr_c4_valids", 64'({AWVALID, WVALID}), 64'b01);
        WREADY = 1'b1;
        wd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wd_cnt += int'(wr_done);
            step();
        end
        chk("wr_done_count", 64'(wd_cnt), 64'd1);
        chk("wr_err_a", 64'(wr_err), 64'd0);

        // Same-cycle write + read: write first, then read, busy held throughout
        slave(1'b1, 1'b1, 32'h0BADF00D, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        wr_en = 1'b1; rd_en = 1'b1;
        Write_Address = 32'h04; Write_Data = 32'hA5A5A5A5; Read_Address = 32'h08;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        wr_c = 0; rd_c = 0; busy_drop = 0; seen = '0;
        for (int i = 1; i <= 12; i++) begin
            if (wr_done && wr_c == 0) wr_c = i;
            if (rd_valid && rd_c == 0) rd_c = i;
            if (!busy && rd_c == 0) busy_drop++;
            if (ARVALID) seen = ARADDR;
            step();
        end
        chk("coll_wr_done_cycle", 64'(wr_c), 64'd3);
        chk("coll_rd_valid_cycle", 64'(rd_c), 64'd5);
        chk("coll_busy_gaps", 64'(busy_drop), 64'd0);
        chk("coll_araddr", 64'(seen), 64'h08);
        chk("coll_rd_data", 64'(rd_data), 64'h0BADF00D);

        // Error responses; requests while busy are dropped
        slave(1'b1, 1'b1, 32'h11112222, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        wr_en = 1'b1; Write_Address = 32'h30; Write_Data = 32'h0000_0030;
        step();
        wr_en = 1'b1; rd_en = 1'b1; Write_Address = 32'h99; Read_Address = 32'h40;
        step();
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        wd_cnt = 0; ar_cnt = 0; aw_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wd_cnt += int'(wr_done);
            ar_cnt += int'(ARVALID);
            aw_cnt += int'(AWVALID);
            step();
        end
        chk("busy_drop_wr_done", 64'(wd_cnt), 64'd1);
        chk("busy_drop_ar", 64'(ar_cnt), 64'd0);
        chk("busy_drop_aw", 64'(aw_cnt), 64'd0);
        chk("wr_err_b", 64'(wr_err), 64'd1);
        chk("awaddr_kept", 64'(AWADDR), 64'h30);
        do_read(32'h44, lat, seen);
        chk("rd_err_b", 64'(rd_err), 64'd1);
        chk("rd_data_b", 64'(rd_data), 64'h11112222);
        step();

        // Asynchronous reset while waiting for read data
        slave(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd_en = 1'b1; Read_Address = 32'h50;
        step();
        rd_en = 1'b0;
        step();
        chk("pre_rst_rready", 64'(RREADY), 64'd1);
        #2 ARESET = 1'b1;
        #1;
        chk("async_rst_ctrl", 64'(dut_ctrl()), 64'd0);
        chk("async_rst_data", 64'({rd_data, ARADDR}), 64'd0);
        chk("async_rst_wr", 64'({AWADDR, WDATA}), 64'd0);
        step();
        ARESET = 1'b0;
        step();
        slave(1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_read(32'h0C, lat, seen);
        chk("post_rst_latency", 64'(lat), 64'd3);
        chk("post_rst_araddr", 64'(seen), 64'h0C);
        chk("post_rst_rd_data", 64'(rd_data), 64'hCAFEF00D);
        step();

        // Random slave timing and request traffic
        for (int i = 0; i < 1500; i++) begin
            slave(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), $urandom(),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 3) == 0));
            rd_en = 1'($urandom_range(0, 2) == 0);
            wr_en = 1'($urandom_range(0, 2) == 0);
            Read_Address  = $urandom();
            Write_Address = $urandom();
            Write_Data    = $urandom();
            step();
        end
        rd_en = 1'b0; wr_en = 1'b0;
        slave(1'b1, 1'b1, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("drain_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
